// File: rtl/compare_result_tracker.sv
// ---------------------------------------------------------------------------
// compare_result_tracker
//
// Sequential stage behind the 4-bit magnitude comparator. It registers
// samples (A, B, R = {G,E,L}) under in_valid. It keeps:
//   - saturating per-outcome counts
//   - a running maximum of A
//   - the last accepted result
//   - a lock indication after LOCK_N consecutive equal results
// Malformed results are rejected and raise a sticky error.
//
// Optional feature macro: TRACKER_CHECK_EN
//   When defined, the block also rejects a one-hot R that disagrees with its
//   own {A>B, A==B, A<B}. When undefined, only the one-hot check applies.
//
// Parameters
//   CNT_W   width of each outcome counter
//   LOCK_N  consecutive E results required to lock (1..15)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   sample strobe
//   A, B      in   comparator operands (4 bits)
//   R         in   comparator result {G,E,L}, expected one-hot
//   clr       in   synchronous clear, same effect as reset, beats in_valid
//   g_cnt     out  accepted G results (saturating)
//   e_cnt     out  accepted E results (saturating)
//   l_cnt     out  accepted L results (saturating)
//   run_max   out  largest A among accepted samples
//   last_r    out  R of the most recent accepted sample
//   locked    out  lock FSM is in LOCKED
//   err       out  sticky reject flag since reset/clr
//
// Lock FSM
//   state  | meaning
//   IDLE   | no sample seen since reset/clr
//   TRACK  | samples seen, E run shorter than LOCK_N
//   LOCKED | last LOCK_N accepted samples were all E, no break since
// ---------------------------------------------------------------------------
module compare_result_tracker #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic [2:0]       R,
  input  logic             clr,
  output logic [CNT_W-1:0] g_cnt,
  output logic [CNT_W-1:0] e_cnt,
  output logic [CNT_W-1:0] l_cnt,
  output logic [3:0]       run_max,
  output logic [2:0]       last_r,
  output logic             locked,
  output logic             err
);

`ifdef TRACKER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);
  localparam logic [3:0]       RUN_ONE = 4'd1;

  localparam logic [2:0] R_G = 3'b100;
  localparam logic [2:0] R_E = 3'b010;
  localparam logic [2:0] R_L = 3'b001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] eq_run;

  // Sample classification
  logic       r_onehot;
  logic [2:0] r_ref;
  logic       r_agree;
  logic       take;
  logic       sample_ok;
  logic       sample_bad;
  logic [3:0] eq_run_nxt;
  state_t     state_nxt;

  always_comb begin
    r_onehot = (R == R_G) || (R == R_E) || (R == R_L);
    // The reference result is always built. It is only used when the check
    // is enabled, so the default build constant-folds it away.
    r_ref    = {(A > B), (A == B), (A < B)};
    r_agree  = (R == r_ref);
    take       = in_valid && !clr;
    sample_ok  = take && r_onehot && (!CHECK_EN || r_agree);
    sample_bad = take && !sample_ok;
  end

  // An E extends the run, saturating at LOCK_N. Any other accepted result or
  // a reject breaks the run. Idle cycles leave it alone.
  always_comb begin
    eq_run_nxt = eq_run;
    if (sample_bad) begin
      eq_run_nxt = 4'd0;
    end else if (sample_ok) begin
      if (R == R_E) begin
        if (eq_run < LOCK_V) eq_run_nxt = eq_run + RUN_ONE;
      end else begin
        eq_run_nxt = 4'd0;
      end
    end
  end

  // Every valid sample leaves IDLE. The only way into LOCKED is an accepted
  // E that brings the run to LOCK_N. When LOCK_N=1 this also covers the
  // direct IDLE -> LOCKED step.
  always_comb begin
    state_nxt = state;
    if (take) begin
      if (sample_ok && (R == R_E) && (eq_run_nxt == LOCK_V)) begin
        state_nxt = LOCKED;
      end else begin
        state_nxt = TRACK;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      eq_run  <= 4'd0;
      g_cnt   <= '0;
      e_cnt   <= '0;
      l_cnt   <= '0;
      run_max <= 4'd0;
      last_r  <= 3'b000;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      eq_run  <= 4'd0;
      g_cnt   <= '0;
      e_cnt   <= '0;
      l_cnt   <= '0;
      run_max <= 4'd0;
      last_r  <= 3'b000;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state  <= state_nxt;
      eq_run <= eq_run_nxt;
      locked <= (state_nxt == LOCKED);

      if (sample_bad) err <= 1'b1;

      if (sample_ok) begin
        last_r <= R;
        if (A > run_max) run_max <= A;
        unique case (R)
          R_G: if (g_cnt != CNT_MAX) g_cnt <= g_cnt + CNT_ONE;
          R_E: if (e_cnt != CNT_MAX) e_cnt <= e_cnt + CNT_ONE;
          R_L: if (l_cnt != CNT_MAX) l_cnt <= l_cnt + CNT_ONE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_compare_result_tracker.sv
// ---------------------------------------------------------------------------
// tb_compare_result_tracker
//
// Scoreboard bench. The driver applies one stimulus per cycle. For each one
// it advances a behavioural model and queues the state the DUT should show
// after the capturing edge. A separate monitor pops one entry per cycle and
// compares it. Directed sequences come first, followed by random traffic.
// ---------------------------------------------------------------------------
module tb_compare_result_tracker;

  localparam int CNT_W  = 2;
  localparam int LOCK_N = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [3:0]       a_in = 4'd0;
  logic [3:0]       b_in = 4'd0;
  logic [2:0]       r_in = 3'd0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] g_cnt, e_cnt, l_cnt;
  logic [3:0]       run_max;
  logic [2:0]       last_r;
  logic             locked, err;

  compare_result_tracker #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a_in), .B(b_in), .R(r_in),
    .clr(clr), .g_cnt(g_cnt), .e_cnt(e_cnt), .l_cnt(l_cnt), .run_max(run_max),
    .last_r(last_r), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] g;
    logic [CNT_W-1:0] e;
    logic [CNT_W-1:0] l;
    logic [3:0]       mx;
    logic [2:0]       lr;
    logic             lk;
    logic             er;
  } obs_t;

  obs_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Behavioural model: plain counts. The lock condition is "at least LOCK_N
  // accepted E in a row since the last break".
  int   m_g, m_e, m_l, m_max, m_last, m_run, m_err;

  function automatic void model_reset();
    m_g = 0; m_e = 0; m_l = 0; m_max = 0; m_last = 0; m_run = 0; m_err = 0;
  endfunction

  function automatic int ref_r(input int a, input int b);
    if (a > b) return 4;
    if (a == b) return 2;
    return 1;
  endfunction

  function automatic void model_step(input bit v, input int a, input int b,
                                     input int r, input bit c);
    bit ok;
    if (c) begin
      model_reset();
    end else if (v) begin
      ok = (r == 4) || (r == 2) || (r == 1);
`ifdef TRACKER_CHECK_EN
      ok = ok && (r == ref_r(a, b));
`endif
      if (!ok) begin
        m_err = 1;
        m_run = 0;
      end else begin
        if (r == 4) m_g = (m_g < CMAX) ? m_g + 1 : CMAX;
        if (r == 2) m_e = (m_e < CMAX) ? m_e + 1 : CMAX;
        if (r == 1) m_l = (m_l < CMAX) ? m_l + 1 : CMAX;
        m_last = r;
        if (a > m_max) m_max = a;
        m_run = (r == 2) ? m_run + 1 : 0;
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.g  = CNT_W'(m_g);
    o.e  = CNT_W'(m_e);
    o.l  = CNT_W'(m_l);
    o.mx = 4'(m_max);
    o.lr = 3'(m_last);
    o.lk = (m_run >= LOCK_N);
    o.er = (m_err != 0);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.g = g_cnt; o.e = e_cnt; o.l = l_cnt; o.mx = run_max;
    o.lr = last_r; o.lk = locked; o.er = err;
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got g=%0d e=%0d l=%0d max=%0d last=%b lk=%b err=%b, required g=%0d e=%0d l=%0d max=%0d last=%b lk=%b err=%b",
               name, cyc, act.g, act.e, act.l, act.mx, act.lr, act.lk, act.er,
               exp.g, exp.e, exp.l, exp.mx, exp.lr, exp.lk, exp.er);
    end
  endtask

  // Monitor: one expected observation per capturing edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() != 0) begin
        e = q.pop_front();
        check_obs("scoreboard", dut_obs(), e);
      end
    end
  end

  // The driver always runs at posedge+2, so each call targets the next edge.
  task automatic drive(input bit v, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] r, input bit c);
    in_valid = v; a_in = a; b_in = b; r_in = r; clr = c;
    model_step(v, int'(a), int'(b), int'(r), c);
    q.push_back(model_obs());
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
  endtask

  task automatic do_clr();
    drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic [2:0] rr;
    int sel;
    bit rv, rc;

    model_reset();
    #12;
    check_obs("reset_state", dut_obs(), '0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Basic three outcomes
    drive(1'b1, 4'b1010, 4'b0101, 3'b100, 1'b0);
    drive(1'b1, 4'b0011, 4'b1100, 3'b001, 1'b0);
    drive(1'b1, 4'b1111, 4'b1111, 3'b010, 1'b0);
    check("basic_g", g_cnt, 1);
    check("basic_e", e_cnt, 1);
    check("basic_l", l_cnt, 1);
    check("basic_max", run_max, 15);
    check("basic_last", last_r, 2);
    check("basic_locked", locked, 0);
    check("basic_err", err, 0);

    // Lock after three E with an idle gap, then a G breaks it
    do_clr();
    drive(1'b1, 4'b1010, 4'b1010, 3'b010, 1'b0);
    drive(1'b1, 4'b1010, 4'b1010, 3'b010, 1'b0);
    check("lock_not_yet", locked, 0);
    idle();
    check("lock_gap_hold", locked, 0);
    drive(1'b1, 4'b1010, 4'b1010, 3'b010, 1'b0);
    check("lock_rise", locked, 1);
    drive(1'b1, 4'b1110, 4'b1101, 3'b100, 1'b0);
    check("lock_fall", locked, 0);
    check("lock_g_cnt", g_cnt, 1);

    // Malformed results
    drive(1'b1, 4'b0001, 4'b0001, 3'b110, 1'b0);
    drive(1'b1, 4'b0001, 4'b0001, 3'b000, 1'b0);
    check("bad_err", err, 1);
    check("bad_g", g_cnt, 1);
    check("bad_e", e_cnt, 3);
    check("bad_l", l_cnt, 0);
    check("bad_last", last_r, 4);
    do_clr();
    check("clr_err", err, 0);

    // Counter saturation
    for (int i = 0; i < 5; i++) drive(1'b1, 4'd5, 4'd2, 3'b100, 1'b0);
    check("sat_g", g_cnt, CMAX);
    check("sat_e", e_cnt, 0);
    check("sat_l", l_cnt, 0);

    // One-hot R that disagrees with A vs B
    do_clr();
    drive(1'b1, 4'b0001, 4'b0000, 3'b001, 1'b0);
`ifdef TRACKER_CHECK_EN
    check("chk_err", err, 1);
    check("chk_l", l_cnt, 0);
`else
    check("chk_err", err, 0);
    check("chk_l", l_cnt, 1);
`endif

    // Asynchronous reset while locked, then clr beating a valid sample
    do_clr();
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd9, 4'd9, 3'b010, 1'b0);
    check("pre_rst_locked", locked, 1);
    rst = 1'b1;
    #1;
    check_obs("async_rst", dut_obs(), '0);
    model_reset();
    q.push_back(model_obs());
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(1'b1, 4'd7, 4'd3, 3'b100, 1'b0);
    check("post_rst_accept", g_cnt, 1);
    drive(1'b1, 4'd7, 4'd3, 3'b100, 1'b1);
    check_obs("clr_drops_sample", dut_obs(), '0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 99));
      if (sel < 70)      rr = 3'(ref_r(int'(ra), int'(rb)));
      else if (sel < 85) rr = 3'(1 << $urandom_range(0, 2));
      else               rr = 3'($urandom_range(0, 7));
      rv = ($urandom_range(0, 9) < 8);
      rc = ($urandom_range(0, 99) < 3);
      drive(rv, ra, rb, rr, rc);
    end
    idle();

    // Drain
    for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/compare_result_tracker.md
# compare_result_tracker

Sequential stage directly downstream of the 4-bit magnitude comparator. It registers the comparator's inputs A, B and its result R = {G,E,L} under a valid strobe, and keeps saturating per-outcome counts, a running maximum of A, and the last accepted result. A lock FSM asserts `locked` after LOCK_N consecutive equal results. Malformed results are rejected and flagged on a sticky error.

## Interface
- CNT_W, 8: width of each outcome counter.
- LOCK_N, 3: consecutive E results required to lock; legal range 1..15.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample strobe; A, B, R are captured on any edge where it is 1.
- A  in  4  comparator operand A.
- B  in  4  comparator operand B.
- R  in  3  comparator result {G,E,L}; must be one-hot.
- clr  in  1  synchronous clear of all tracking state.
- g_cnt  out  CNT_W  accepted G results.
- e_cnt  out  CNT_W  accepted E results.
- l_cnt  out  CNT_W  accepted L results.
- run_max  out  4  largest A among accepted samples.
- last_r  out  3  R of the most recent accepted sample.
- locked  out  1  lock FSM is in LOCKED.
- err  out  1  sticky: at least one sample rejected since reset/clr.

## Operation
- Reset (rst=1, asynchronous) and clr (synchronous) have the same effect. All counters go to 0, run_max=0, last_r=3'b000, locked=0, err=0, eq_run=0, and the FSM goes to IDLE.
- clr has priority over in_valid in the same cycle. That sample is dropped.
- Sample acceptance: a sample is accepted when in_valid=1, clr=0, and R is one-hot (exactly one of 100, 010, 001). With the check macro defined, R must also agree with A vs B.
- Rejected sample:
  - sets err.
  - clears eq_run.
  - leaves counters, run_max and last_r unchanged.
  - forces the FSM from LOCKED to TRACK, and from IDLE to TRACK.
- Accepted sample:
  - increments the matching counter, saturating at 2^CNT_W-1.
  - sets last_r=R.
  - sets run_max = max(run_max, A), unsigned.
  - updates eq_run: E increments it, saturating at LOCK_N; G or L clears it.
- FSM states: IDLE, TRACK, LOCKED.
  - IDLE: no sample seen since reset/clr. Any valid sample moves to TRACK, or directly to LOCKED if it is an accepted E and LOCK_N=1.
  - TRACK: moves to LOCKED on the edge where eq_run reaches LOCK_N.
  - LOCKED: any accepted G/L or any rejected sample moves to TRACK. An accepted E stays in LOCKED.
  - locked = (state == LOCKED).
- in_valid=0 cycles hold all state and do not break an E run.

## Timing
- All outputs are registered. Effects of a sample edge are visible after that edge, one cycle after it is presented. There is no combinational input-to-output path.
- Throughput is one sample per cycle with no back-pressure. There is no ready signal.
- Lock timing: with LOCK_N=N, locked rises on the edge capturing the N-th consecutive accepted E. It falls on the edge capturing the first breaking sample.
- Counter saturation is independent per counter. Other counters keep counting.
- Reset asserted mid-stream clears state immediately, asynchronously. The first edge after rst deasserts may accept a sample.

## Configuration
- TRACKER_CHECK_EN defined: the block computes its own {A>B, A==B, A<B} and rejects any one-hot R that disagrees. The rejection sets err exactly as for a non-one-hot R.
- TRACKER_CHECK_EN undefined: only the one-hot check applies, and A and B feed run_max only. A one-hot R is accepted regardless of A and B.

## Test plan
- Reset, then the three samples (A,B,R) = (1010,0101,100), (0011,1100,001), (1111,1111,010). Required: g_cnt=1, l_cnt=1, e_cnt=1, run_max=1111, last_r=010, locked=0, err=0.
- LOCK_N=3, E samples A=B=1010 on three consecutive valid cycles, with one in_valid=0 gap between the 2nd and 3rd. Required: locked=1 after the 3rd; a following (1110,1101,100) drops locked and gives g_cnt=1.
- Sample with R=3'b110, then R=3'b000. Required: err=1, all counters unchanged, last_r unchanged. A subsequent clr returns err=0.
- CNT_W=2, five accepted G samples. Required: g_cnt saturates at 3; e_cnt and l_cnt stay at 0.
- With TRACKER_CHECK_EN defined, sample (0001,0000,001). Required: rejected, err=1, l_cnt=0. With the macro undefined, the same sample is accepted, giving l_cnt=1, err=0.
- Assert rst asynchronously mid-cycle while locked=1 with counts non-zero. Required: all outputs 0 before the next edge. Assert clr together with a valid sample in the same cycle. Required: the sample is dropped and all outputs are 0.
